// File: rtl/regs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : regs_pkg
// Purpose : Shared constants for the register-bank write-port arbiter:
//           bank write codes, execute-stage write types, source indices,
//           default widths and the execute type-to-code mapping.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package regs_pkg;

  localparam int LARGURA_DADO_PADRAO = 16;
  localparam int LARGURA_END_PADRAO  = 5;

  // Bank write codes; the bank holds its contents on CTRL_NENHUM.
  localparam logic [2:0] CTRL_IMEDIATO = 3'b000;
  localparam logic [2:0] CTRL_TRES_REG = 3'b001;
  localparam logic [2:0] CTRL_LOAD     = 3'b010;
  localparam logic [2:0] CTRL_LOADI    = 3'b011;
  localparam logic [2:0] CTRL_INPUT    = 3'b100;
  localparam logic [2:0] CTRL_NENHUM   = 3'b111;

  // Execute-stage write types.
  localparam logic [1:0] TIPO_IMEDIATO  = 2'b00;
  localparam logic [1:0] TIPO_TRES_REG  = 2'b01;
  localparam logic [1:0] TIPO_RESERVADO = 2'b10;
  localparam logic [1:0] TIPO_LOADI     = 2'b11;

  // Source indices, also the round-robin order.
  localparam int         NUM_FONTES = 3;
  localparam logic [1:0] FONTE_EXE  = 2'd0;
  localparam logic [1:0] FONTE_MEM  = 2'd1;
  localparam logic [1:0] FONTE_ENT  = 2'd2;

  // The reserved type is folded onto the 3-register code.
  function automatic logic [2:0] codigo_exe(input logic [1:0] tipo);
    logic [2:0] codigo;
    case (tipo)
      TIPO_IMEDIATO: codigo = CTRL_IMEDIATO;
      TIPO_LOADI:    codigo = CTRL_LOADI;
      default:       codigo = CTRL_TRES_REG;
    endcase
    return codigo;
  endfunction

endpackage
`default_nettype wire

// File: rtl/buffer_fonte.sv
`default_nettype none
// ============================================================================
// Module  : buffer_fonte
// Purpose : One-entry holding buffer for a write producer. Captures address,
//           data and bank write code on a valid/ready transfer and empties
//           when granted, unless refilled at the same edge.
// Ports   : clk, rst_n         - clock, async active-low reset
//           valido, pronto     - producer handshake
//           endereco_entrada, dado_entrada, codigo_entrada - offered write
//           concedido          - arbiter grant to this buffer this cycle
//           cheio, endereco_saida, dado_saida, codigo_saida - buffer state
// Revision: 1.0 - initial release
// ============================================================================
module buffer_fonte
  import regs_pkg::*;
#(
  parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int LARGURA_END  = LARGURA_END_PADRAO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valido,
  output logic                    pronto,
  input  logic [LARGURA_END-1:0]  endereco_entrada,
  input  logic [LARGURA_DADO-1:0] dado_entrada,
  input  logic [2:0]              codigo_entrada,
  input  logic                    concedido,
  output logic                    cheio,
  output logic [LARGURA_END-1:0]  endereco_saida,
  output logic [LARGURA_DADO-1:0] dado_saida,
  output logic [2:0]              codigo_saida
);

  logic                    r_cheio;
  logic [LARGURA_END-1:0]  r_endereco;
  logic [LARGURA_DADO-1:0] r_dado;
  logic [2:0]              r_codigo;

  // A granted buffer hands its contents to the output stage this edge, so it
  // can take a new entry at the same edge.
  assign pronto = !r_cheio || concedido;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cheio    <= 1'b0;
      r_endereco <= '0;
      r_dado     <= '0;
      r_codigo   <= CTRL_NENHUM;
    end else if (valido && pronto) begin
      r_cheio    <= 1'b1;
      r_endereco <= endereco_entrada;
      r_dado     <= dado_entrada;
      r_codigo   <= codigo_entrada;
    end else if (concedido) begin
      r_cheio    <= 1'b0;
    end
  end

  assign cheio          = r_cheio;
  assign endereco_saida = r_endereco;
  assign dado_saida     = r_dado;
  assign codigo_saida   = r_codigo;

endmodule
`default_nettype wire

// File: rtl/arbitro_escrita_registradores.sv
`default_nettype none
// ============================================================================
// Module  : arbitro_escrita_registradores
// Purpose : Write-port arbiter for the 32x16 register bank. Execute, memory
//           load and input-device producers each own a one-entry buffer; a
//           round-robin arbiter issues at most one registered write per cycle.
// Ports   : clk, rst_n                          - clock, async active-low reset
//           exe_valido/pronto/tipo/end/dado      - execute-stage producer
//           mem_valido/pronto/end/dado           - memory load producer
//           ent_valido/pronto/end/dado           - input-device producer
//           controle_registradores, endereco_registrador1, dado_escrita
//                                                - registered bank write port
//           ocupado                              - any buffer full / write live
//           consulta_end1, consulta_end2, conflito
//                                                - hazard query (optional)
// Config  : ARBITRO_SCOREBOARD_EN adds the hazard query ports.
// Revision: 1.0 - initial release
// ============================================================================
module arbitro_escrita_registradores
  import regs_pkg::*;
#(
  parameter int LARGURA_DADO = LARGURA_DADO_PADRAO,
  parameter int LARGURA_END  = LARGURA_END_PADRAO
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    exe_valido,
  output logic                    exe_pronto,
  input  logic [1:0]              exe_tipo,
  input  logic [LARGURA_END-1:0]  exe_end,
  input  logic [LARGURA_DADO-1:0] exe_dado,
  input  logic                    mem_valido,
  output logic                    mem_pronto,
  input  logic [LARGURA_END-1:0]  mem_end,
  input  logic [LARGURA_DADO-1:0] mem_dado,
  input  logic                    ent_valido,
  output logic                    ent_pronto,
  input  logic [LARGURA_END-1:0]  ent_end,
  input  logic [LARGURA_DADO-1:0] ent_dado,
  output logic [2:0]              controle_registradores,
  output logic [LARGURA_END-1:0]  endereco_registrador1,
  output logic [LARGURA_DADO-1:0] dado_escrita,
  output logic                    ocupado
`ifdef ARBITRO_SCOREBOARD_EN
  ,
  input  logic [LARGURA_END-1:0]  consulta_end1,
  input  logic [LARGURA_END-1:0]  consulta_end2,
  output logic                    conflito
`endif
);

  // Per-source vectors, indexed by FONTE_*.
  logic [NUM_FONTES-1:0]   w_valido;
  logic [NUM_FONTES-1:0]   w_pronto;
  logic [NUM_FONTES-1:0]   w_cheio;
  logic [NUM_FONTES-1:0]   w_concedido;
  logic [LARGURA_END-1:0]  w_end_in   [NUM_FONTES];
  logic [LARGURA_DADO-1:0] w_dado_in  [NUM_FONTES];
  logic [2:0]              w_cod_in   [NUM_FONTES];
  logic [LARGURA_END-1:0]  w_end_buf  [NUM_FONTES];
  logic [LARGURA_DADO-1:0] w_dado_buf [NUM_FONTES];
  logic [2:0]              w_cod_buf  [NUM_FONTES];

  logic                    w_tem_concessao;
  logic [1:0]              w_vencedor;
  logic [2:0]              w_indice;
  logic [1:0]              w_prox_seguinte;

  logic [1:0]              r_prox;
  logic [2:0]              r_controle;
  logic [LARGURA_END-1:0]  r_endereco;
  logic [LARGURA_DADO-1:0] r_dado;

  assign w_valido = {ent_valido, mem_valido, exe_valido};

  assign w_end_in[FONTE_EXE]  = exe_end;
  assign w_end_in[FONTE_MEM]  = mem_end;
  assign w_end_in[FONTE_ENT]  = ent_end;
  assign w_dado_in[FONTE_EXE] = exe_dado;
  assign w_dado_in[FONTE_MEM] = mem_dado;
  assign w_dado_in[FONTE_ENT] = ent_dado;
  assign w_cod_in[FONTE_EXE]  = codigo_exe(exe_tipo);
  assign w_cod_in[FONTE_MEM]  = CTRL_LOAD;
  assign w_cod_in[FONTE_ENT]  = CTRL_INPUT;

  for (genvar g = 0; g < NUM_FONTES; g++) begin : g_buffers
    buffer_fonte #(
      .LARGURA_DADO (LARGURA_DADO),
      .LARGURA_END  (LARGURA_END)
    ) u_buffer (
      .clk              (clk),
      .rst_n            (rst_n),
      .valido           (w_valido[g]),
      .pronto           (w_pronto[g]),
      .endereco_entrada (w_end_in[g]),
      .dado_entrada     (w_dado_in[g]),
      .codigo_entrada   (w_cod_in[g]),
      .concedido        (w_concedido[g]),
      .cheio            (w_cheio[g]),
      .endereco_saida   (w_end_buf[g]),
      .dado_saida       (w_dado_buf[g]),
      .codigo_saida     (w_cod_buf[g])
    );
  end

  assign exe_pronto = w_pronto[FONTE_EXE];
  assign mem_pronto = w_pronto[FONTE_MEM];
  assign ent_pronto = w_pronto[FONTE_ENT];

  // Round-robin search starting at r_prox. Only buffer occupancy feeds the
  // grant, so pronto never depends combinationally on valido.
  always_comb begin
    w_tem_concessao = 1'b0;
    w_vencedor      = r_prox;
    w_indice        = 3'd0;
    w_concedido     = '0;
    for (int k = 0; k < NUM_FONTES; k++) begin
      w_indice = {1'b0, r_prox} + 3'(k);
      if (w_indice >= 3'(NUM_FONTES)) begin
        w_indice = w_indice - 3'(NUM_FONTES);
      end
      if (!w_tem_concessao && w_cheio[w_indice[1:0]]) begin
        w_tem_concessao = 1'b1;
        w_vencedor      = w_indice[1:0];
      end
    end
    if (w_tem_concessao) begin
      w_concedido = 3'b001 << w_vencedor;
    end
  end

  assign w_prox_seguinte = (w_vencedor == FONTE_ENT) ? FONTE_EXE : w_vencedor + 2'd1;

  // Registered write stage; address and data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prox     <= FONTE_EXE;
      r_controle <= CTRL_NENHUM;
      r_endereco <= '0;
      r_dado     <= '0;
    end else if (w_tem_concessao) begin
      r_prox     <= w_prox_seguinte;
      r_controle <= w_cod_buf[w_vencedor];
      r_endereco <= w_end_buf[w_vencedor];
      r_dado     <= w_dado_buf[w_vencedor];
    end else begin
      r_controle <= CTRL_NENHUM;
    end
  end

  assign controle_registradores = r_controle;
  assign endereco_registrador1  = r_endereco;
  assign dado_escrita           = r_dado;
  assign ocupado                = (|w_cheio) || (r_controle != CTRL_NENHUM);

`ifdef ARBITRO_SCOREBOARD_EN
  // Flags a query address that still has a write pending or in flight.
  always_comb begin
    conflito = 1'b0;
    for (int k = 0; k < NUM_FONTES; k++) begin
      if (w_cheio[k] && ((w_end_buf[k] == consulta_end1) || (w_end_buf[k] == consulta_end2))) begin
        conflito = 1'b1;
      end
    end
    if ((r_controle != CTRL_NENHUM) &&
        ((r_endereco == consulta_end1) || (r_endereco == consulta_end2))) begin
      conflito = 1'b1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_arbitro_escrita_registradores.sv
`default_nettype none
// ============================================================================
// Module  : tb_arbitro_escrita_registradores
// Purpose : Self-checking bench for the register write-port arbiter. Accepted
//           writes are queued per source; a negedge monitor pops and compares
//           every write the output stage presents.
// Revision: 1.0 - initial release
// ============================================================================
module tb_arbitro_escrita_registradores;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exe_valido, exe_pronto;
  logic [1:0]  exe_tipo;
  logic [4:0]  exe_end;
  logic [15:0] exe_dado;
  logic        mem_valido, mem_pronto;
  logic [4:0]  mem_end;
  logic [15:0] mem_dado;
  logic        ent_valido, ent_pronto;
  logic [4:0]  ent_end;
  logic [15:0] ent_dado;
  logic [2:0]  controle_registradores;
  logic [4:0]  endereco_registrador1;
  logic [15:0] dado_escrita;
  logic        ocupado;
`ifdef ARBITRO_SCOREBOARD_EN
  logic [4:0]  consulta_end1, consulta_end2;
  logic        conflito;
`endif

  always #5 clk = ~clk;

  arbitro_escrita_registradores dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .exe_valido             (exe_valido),
    .exe_pronto             (exe_pronto),
    .exe_tipo               (exe_tipo),
    .exe_end                (exe_end),
    .exe_dado               (exe_dado),
    .mem_valido             (mem_valido),
    .mem_pronto             (mem_pronto),
    .mem_end                (mem_end),
    .mem_dado               (mem_dado),
    .ent_valido             (ent_valido),
    .ent_pronto             (ent_pronto),
    .ent_end                (ent_end),
    .ent_dado               (ent_dado),
    .controle_registradores (controle_registradores),
    .endereco_registrador1  (endereco_registrador1),
    .dado_escrita           (dado_escrita),
    .ocupado                (ocupado)
`ifdef ARBITRO_SCOREBOARD_EN
    ,
    .consulta_end1          (consulta_end1),
    .consulta_end2          (consulta_end2),
    .conflito               (conflito)
`endif
  );

  typedef struct packed {
    logic [2:0]  cod;
    logic [4:0]  ende;
    logic [15:0] dado;
  } escrita_t;

  escrita_t fila_exe[$];
  escrita_t fila_mem[$];
  escrita_t fila_ent[$];
  int       log_fontes[$];
  int       checks   = 0;
  int       failures = 0;

  function automatic logic [2:0] cod_exe(input logic [1:0] tipo);
    case (tipo)
      2'b00:   return 3'b000;
      2'b11:   return 3'b011;
      default: return 3'b001;
    endcase
  endfunction

  // Scoreboard monitor: every live write must match the oldest accepted
  // entry of the source its code identifies.
  always @(negedge clk) begin : monitor
    escrita_t obs;
    escrita_t esp;
    int       f;
    if (rst_n === 1'b1 && controle_registradores !== 3'b111) begin
      obs = {controle_registradores, endereco_registrador1, dado_escrita};
      case (controle_registradores)
        3'b000, 3'b001, 3'b011: f = 0;
        3'b010:                 f = 1;
        3'b100:                 f = 2;
        default:                f = -1;
      endcase
      checks++;
      if (f < 0) begin
        failures++;
        $display("FAIL sb_code observed=%b required=a defined write code", controle_registradores);
      end else begin
        log_fontes.push_back(f);
        if ((f == 0 && fila_exe.size() == 0) || (f == 1 && fila_mem.size() == 0) ||
            (f == 2 && fila_ent.size() == 0)) begin
          failures++;
          $display("FAIL sb_unexpected observed=%h required=no write from source %0d", obs, f);
        end else begin
          if (f == 0)      esp = fila_exe.pop_front();
          else if (f == 1) esp = fila_mem.pop_front();
          else             esp = fila_ent.pop_front();
          if (obs !== esp) begin
            failures++;
            $display("FAIL sb_write observed=%h required=%h", obs, esp);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst_n      = 1'b0;
    exe_valido = 1'b0;
    mem_valido = 1'b0;
    ent_valido = 1'b0;
    fila_exe.delete();
    fila_mem.delete();
    fila_ent.delete();
    log_fontes.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string nome);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (fila_exe.size() == 0 && fila_mem.size() == 0 && fila_ent.size() == 0 &&
          controle_registradores === 3'b111) break;
    end
    checks++;
    if (fila_exe.size() + fila_mem.size() + fila_ent.size() != 0) begin
      failures++;
      $display("FAIL %s_drain pending=%0d required=0", nome,
               fila_exe.size() + fila_mem.size() + fila_ent.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({controle_registradores, endereco_registrador1, dado_escrita} !== {3'b111, 5'd0, 16'h0}) begin
      failures++;
      $display("FAIL reset_outputs observed=%b/%0d/%h required=111/0/0000",
               controle_registradores, endereco_registrador1, dado_escrita);
    end
    checks++;
    if ({exe_pronto, mem_pronto, ent_pronto, ocupado} !== 4'b1110) begin
      failures++;
      $display("FAIL reset_ready observed=%b required=1110",
               {exe_pronto, mem_pronto, ent_pronto, ocupado});
    end
    // Fill all buffers, let one write reach the output stage, then reset.
    @(negedge clk);
    exe_valido = 1'b1; exe_tipo = 2'b01; exe_end = 5'd9;  exe_dado = 16'h1111;
    mem_valido = 1'b1; mem_end  = 5'd10; mem_dado = 16'h2222;
    ent_valido = 1'b1; ent_end  = 5'd11; ent_dado = 16'h3333;
    fila_exe.push_back({3'b001, 5'd9,  16'h1111});
    fila_mem.push_back({3'b010, 5'd10, 16'h2222});
    fila_ent.push_back({3'b100, 5'd11, 16'h3333});
    @(negedge clk);
    exe_valido = 1'b0; mem_valido = 1'b0; ent_valido = 1'b0;
    @(negedge clk);
    checks++;
    if (controle_registradores !== 3'b001 || ocupado !== 1'b1) begin
      failures++;
      $display("FAIL reset_prefill observed=%b/%b required=001/1", controle_registradores, ocupado);
    end
    #2;
    rst_n = 1'b0;
    fila_mem.delete();
    fila_ent.delete();
    #1;
    checks++;
    if ({controle_registradores, exe_pronto, mem_pronto, ent_pronto, ocupado} !== 7'b1111110) begin
      failures++;
      $display("FAIL reset_async observed=%b required=1111110",
               {controle_registradores, exe_pronto, mem_pronto, ent_pronto, ocupado});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (controle_registradores !== 3'b111 || ocupado !== 1'b0) begin
        failures++;
        $display("FAIL reset_no_write cycle=%0d observed=%b/%b required=111/0",
                 c, controle_registradores, ocupado);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    @(negedge clk);
    exe_valido = 1'b1; exe_tipo = 2'b01; exe_end = 5'd5; exe_dado = 16'h1234;
    fila_exe.push_back({3'b001, 5'd5, 16'h1234});
    @(negedge clk);
    exe_valido = 1'b0;
    checks++;
    if (controle_registradores !== 3'b111 || ocupado !== 1'b1) begin
      failures++;
      $display("FAIL single_latency observed=%b/%b required=111/1", controle_registradores, ocupado);
    end
    @(negedge clk);
    checks++;
    if ({controle_registradores, endereco_registrador1, dado_escrita} !== {3'b001, 5'd5, 16'h1234}) begin
      failures++;
      $display("FAIL single_write observed=%b/%0d/%h required=001/5/1234",
               controle_registradores, endereco_registrador1, dado_escrita);
    end
    @(negedge clk);
    checks++;
    if (controle_registradores !== 3'b111 || ocupado !== 1'b0) begin
      failures++;
      $display("FAIL single_idle observed=%b/%b required=111/0", controle_registradores, ocupado);
    end
  endtask

  task automatic test_contention();
    logic [2:0] esperado [3];
    esperado[0] = 3'b001; esperado[1] = 3'b010; esperado[2] = 3'b100;
    do_reset();
    @(negedge clk);
    exe_valido = 1'b1; exe_tipo = 2'b01; exe_end = 5'd1; exe_dado = 16'hAAAA;
    mem_valido = 1'b1; mem_end  = 5'd2;  mem_dado = 16'hBBBB;
    ent_valido = 1'b1; ent_end  = 5'd3;  ent_dado = 16'hCCCC;
    fila_exe.push_back({3'b001, 5'd1, 16'hAAAA});
    fila_mem.push_back({3'b010, 5'd2, 16'hBBBB});
    fila_ent.push_back({3'b100, 5'd3, 16'hCCCC});
    @(negedge clk);
    exe_valido = 1'b0; mem_valido = 1'b0; ent_valido = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (controle_registradores !== esperado[i]) begin
        failures++;
        $display("FAIL contention_order slot=%0d observed=%b required=%b",
                 i, controle_registradores, esperado[i]);
      end
    end
    @(negedge clk);
    checks++;
    if (controle_registradores !== 3'b111 || dut.r_prox !== 2'd0) begin
      failures++;
      $display("FAIL contention_end observed=%b/prox=%0d required=111/prox=0",
               controle_registradores, dut.r_prox);
    end
  endtask

  task automatic test_fairness();
    int ne = 0;
    int nm = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      exe_valido = 1'b1; exe_tipo = 2'b00; exe_end = 5'(ne); exe_dado = 16'hE000 + 16'(ne);
      mem_valido = 1'b1; mem_end  = 5'(16 + nm); mem_dado = 16'hD000 + 16'(nm);
      if (exe_pronto === 1'b1) begin
        fila_exe.push_back({3'b000, 5'(ne), 16'hE000 + 16'(ne)});
        ne++;
      end
      if (mem_pronto === 1'b1) begin
        fila_mem.push_back({3'b010, 5'(16 + nm), 16'hD000 + 16'(nm)});
        nm++;
      end
    end
    @(negedge clk);
    exe_valido = 1'b0; mem_valido = 1'b0;
    drain("fairness");
    checks++;
    if (ne != 6 || nm != 5) begin
      failures++;
      $display("FAIL fairness_accepts observed=exe%0d/mem%0d required=exe6/mem5", ne, nm);
    end
    checks++;
    if (log_fontes.size() != 11) begin
      failures++;
      $display("FAIL fairness_count observed=%0d required=11", log_fontes.size());
    end
    for (int i = 0; i < log_fontes.size(); i++) begin
      checks++;
      if (log_fontes[i] != (i % 2)) begin
        failures++;
        $display("FAIL fairness_alternate slot=%0d observed=%0d required=%0d", i, log_fontes[i], i % 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (exe_pronto !== 1'b1) begin
        failures++;
        $display("FAIL b2b_ready cycle=%0d observed=%b required=1", c, exe_pronto);
      end
      if (c >= 2) begin
        checks++;
        if (controle_registradores !== 3'b011 || dado_escrita !== 16'h5000 + 16'(c - 2)) begin
          failures++;
          $display("FAIL b2b_write cycle=%0d observed=%b/%h required=011/%h",
                   c, controle_registradores, dado_escrita, 16'h5000 + 16'(c - 2));
        end
      end
      exe_valido = 1'b1; exe_tipo = 2'b11; exe_end = 5'(c); exe_dado = 16'h5000 + 16'(c);
      fila_exe.push_back({3'b011, 5'(c), 16'h5000 + 16'(c)});
    end
    @(negedge clk);
    exe_valido = 1'b0;
    drain("b2b");
  endtask

  task automatic test_tipos();
    logic [1:0] tipos [4];
    tipos[0] = 2'b00; tipos[1] = 2'b01; tipos[2] = 2'b10; tipos[3] = 2'b11;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exe_valido = 1'b1; exe_tipo = tipos[c]; exe_end = 5'd0; exe_dado = 16'h0F00 + 16'(c);
      fila_exe.push_back({cod_exe(tipos[c]), 5'd0, 16'h0F00 + 16'(c)});
    end
    @(negedge clk);
    exe_valido = 1'b0;
    drain("tipos");
  endtask

`ifdef ARBITRO_SCOREBOARD_EN
  task automatic test_scoreboard();
    do_reset();
    consulta_end1 = 5'd20;
    consulta_end2 = 5'd7;
    @(negedge clk);
    #1;
    checks++;
    if (conflito !== 1'b0) begin
      failures++;
      $display("FAIL sb_idle observed=%b required=0", conflito);
    end
    mem_valido = 1'b1; mem_end = 5'd7; mem_dado = 16'h7777;
    fila_mem.push_back({3'b010, 5'd7, 16'h7777});
    @(negedge clk);
    mem_valido = 1'b0;
    #1;
    checks++;
    if (conflito !== 1'b1) begin
      failures++;
      $display("FAIL sb_pending observed=%b required=1", conflito);
    end
    @(negedge clk);
    #1;
    checks++;
    if (conflito !== 1'b1) begin
      failures++;
      $display("FAIL sb_inflight observed=%b required=1", conflito);
    end
    @(negedge clk);
    #1;
    checks++;
    if (conflito !== 1'b0) begin
      failures++;
      $display("FAIL sb_drained observed=%b required=0", conflito);
    end
  endtask
`endif

  initial begin
    rst_n      = 1'b0;
    exe_valido = 1'b0; exe_tipo = 2'b00; exe_end = '0; exe_dado = '0;
    mem_valido = 1'b0; mem_end  = '0;    mem_dado = '0;
    ent_valido = 1'b0; ent_end  = '0;    ent_dado = '0;
`ifdef ARBITRO_SCOREBOARD_EN
    consulta_end1 = 5'd31;
    consulta_end2 = 5'd31;
`endif
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_back_to_back();
    test_tipos();
`ifdef ARBITRO_SCOREBOARD_EN
    test_scoreboard();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
